tray_monitor: RTL and testbench

Clocked downstream consumer of the board's tray outputs (tray, tray_amount, no_balls). It synchronises these asynchronous board signals and detects each newly landed ball. Each landed colour is streamed as an ASCII byte over a valid/ready interface through a small FIFO. It also checks the landed sequence against a parameterised expected pattern and flags end of run.

---
 rtl/tray_monitor_if.sv | 9 +
 rtl/tray_monitor.sv | 178 +++++++++++++++++
 tb/tb_tray_monitor.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tray_monitor_if.sv
// Landed-colour byte stream: one ASCII byte per out_valid & out_ready beat.
interface tray_monitor_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/tray_monitor.sv
// tray_fifo: DEPTH-entry FIFO whose head is registered; a push into an empty FIFO is visible next cycle.
// Backpressure: pushes while full with no pop are refused (wr_en low); head holds while not popped.
module tray_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         rd_valid,
  output logic [W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   count, count_nxt;
  logic          wr_en;
  logic [W-1:0]  head_nxt;

  assign full  = (count == (AW+1)'(DEPTH));
  assign wr_en = push & (~full | pop);

  // The head register is loaded with whatever will be the oldest entry after this cycle.
  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = count + (AW+1)'(wr_en) - (AW+1)'(pop);
    if (count_nxt == '0)
      head_nxt = '0;
    else if ((count - (AW+1)'(pop)) == '0)
      head_nxt = push_data;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      rd_data  <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_data;
  end
endmodule

// tray_monitor: syncs board tray outputs, streams each landed colour ('B'/'R') then 'E'; SYNC_STAGES+3 cycles to first byte.
// Backpressure: colours arriving at a full FIFO are dropped (overflow); only the 'E' marker waits for space.
module tray_monitor #(
  parameter int          DEPTH        = 8,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] EXPECTED     = 32'h0,
  parameter int          EXPECTED_LEN = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    tray,
  input  logic [4:0]     tray_amount,
  input  logic           no_balls,
  tray_monitor_if.master stream,
  output logic           done,
  output logic           fail,
  output logic           pass,
  output logic           overflow
);
  localparam logic [6:0] EXP_LEN = 7'(EXPECTED_LEN);

  typedef enum logic [1:0] {TRACK, ENDING, DONE} state_t;

  state_t                      state, state_nxt;
  logic [SYNC_STAGES-1:0][4:0] amt_sync;
  logic [SYNC_STAGES-1:0]      nb_sync;
  logic [4:0]                  amt_prev, amt_stable, rd_idx;
  logic [5:0]                  landed;
  logic                        pending, colour, mismatch, pop, full;
  logic                        push, col_push;
  logic [7:0]                  push_data;

  // tray_amount is multi-bit: only a value seen on two consecutive synced cycles is trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amt_sync   <= '0;
      nb_sync    <= '0;
      amt_prev   <= '0;
      amt_stable <= '0;
    end else begin
      amt_sync <= {amt_sync[SYNC_STAGES-2:0], tray_amount};
      nb_sync  <= {nb_sync[SYNC_STAGES-2:0], no_balls};
      amt_prev <= amt_sync[SYNC_STAGES-1];
      if (amt_sync[SYNC_STAGES-1] == amt_prev)
        amt_stable <= amt_prev;
    end
  end

  assign pending  = (amt_stable != rd_idx);
  assign colour   = tray[rd_idx];
  assign mismatch = ({2'b00, rd_idx} < EXP_LEN) && (colour != EXPECTED[rd_idx]);
  assign pop      = stream.out_valid & stream.out_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    col_push  = 1'b0;
    push_data = 8'h00;
    case (state)
      TRACK: begin
        if (pending) begin
          push      = 1'b1;
          col_push  = 1'b1;
          push_data = colour ? 8'h52 : 8'h42;
        end else if (nb_sync[SYNC_STAGES-1]) begin
          state_nxt = ENDING;
        end
      end
      ENDING: begin
        push_data = 8'h45;
        if (~full | pop) begin
          push      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = TRACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TRACK;
      rd_idx   <= '0;
      landed   <= '0;
      fail     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
      // A dropped colour still consumes its slot so the index keeps tracking the board.
      if (col_push) begin
        rd_idx <= rd_idx + 5'd1;
        if (landed != 6'd63)
          landed <= landed + 6'd1;
        if (mismatch)
          fail <= 1'b1;
        if (full & ~pop)
          overflow <= 1'b1;
      end
    end
  end

  assign pass = done & ~fail & ({1'b0, landed} >= EXP_LEN);

  tray_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .rd_valid  (stream.out_valid),
    .rd_data   (stream.out_data)
  );
endmodule

// File: tb/tb_tray_monitor.sv
// Bench for tray_monitor: two instances (no pattern / pattern 3'b101 over 3 slots) share one board stimulus.
module tb_tray_monitor;
  localparam int          DEPTH = 8;
  localparam int          SYNC  = 2;
  localparam int          LAT   = SYNC + 3;
  localparam logic [31:0] EXP_B = 32'h5;
  localparam int          LEN_B = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tray = '0;
  logic [4:0]  tray_amount = '0;
  logic        no_balls = 1'b0;
  logic        ready = 1'b0;
  logic        done_a, fail_a, pass_a, overflow_a;
  logic        done_b, fail_b, pass_b, overflow_b;

  tray_monitor_if if_a ();
  tray_monitor_if if_b ();
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  tray_monitor #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .EXPECTED(32'h0), .EXPECTED_LEN(0)) dut_a (
    .clk(clk), .rst(rst), .tray(tray), .tray_amount(tray_amount), .no_balls(no_balls),
    .stream(if_a), .done(done_a), .fail(fail_a), .pass(pass_a), .overflow(overflow_a));

  tray_monitor #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .EXPECTED(EXP_B), .EXPECTED_LEN(LEN_B)) dut_b (
    .clk(clk), .rst(rst), .tray(tray), .tray_amount(tray_amount), .no_balls(no_balls),
    .stream(if_b), .done(done_b), .fail(fail_b), .pass(pass_b), .overflow(overflow_b));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected byte stream plus per-instance sticky flags, derived from board landings.
  logic [7:0]  exp_q[$];
  logic [7:0]  pop_log[$];
  int          pop_cyc[$];
  logic [4:0]  model_idx = '0;
  int          model_landed = 0;
  logic        model_ovf = 1'b0;
  logic        model_fail_b = 1'b0;
  logic [31:0] exp_b_v = EXP_B;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Board lands balls up to amt; a held-off sink keeps exactly DEPTH bytes, later colours are lost.
  task automatic land(input logic [4:0] amt);
    while (model_idx != amt) begin
      if (!ready && exp_q.size() >= DEPTH) model_ovf = 1'b1;
      else exp_q.push_back(tray[model_idx] ? 8'h52 : 8'h42);
      if (model_landed < 63) model_landed++;
      if (model_idx < LEN_B && tray[model_idx] != exp_b_v[model_idx]) model_fail_b = 1'b1;
      model_idx = model_idx + 5'd1;
    end
    tray_amount = amt;
  endtask

  task automatic model_clear();
    exp_q.delete();
    pop_log.delete();
    pop_cyc.delete();
    model_idx    = '0;
    model_landed = 0;
    model_ovf    = 1'b0;
    model_fail_b = 1'b0;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    no_balls = 1'b0;
    tray_amount = '0;
    ready = rdy;
    model_clear();
    tick(3);
    rst = 1'b0;
    tick(LAT);
  endtask

  task automatic drain_and_check(input string tag);
    int n = 0;
    while (!(done_a && done_b && exp_q.size() == 0) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      total++;
      $display("FAIL %s_timeout: done_a=%0b done_b=%0b pending=%0d, required done and drained",
               tag, done_a, done_b, exp_q.size());
    end
    check({tag, "_done_a"}, done_a, 1);
    check({tag, "_done_b"}, done_b, 1);
    check({tag, "_fail_a"}, fail_a, 0);
    check({tag, "_fail_b"}, fail_b, model_fail_b);
    check({tag, "_pass_a"}, pass_a, 1);
    check({tag, "_pass_b"}, pass_b, (!model_fail_b && model_landed >= LEN_B));
    check({tag, "_ovf_a"}, overflow_a, model_ovf);
    check({tag, "_ovf_b"}, overflow_b, model_ovf);
  endtask

  task automatic finish_run(input string tag);
    no_balls = 1'b1;
    exp_q.push_back(8'h45);
    drain_and_check(tag);
  endtask

  // Compare process: every popped byte against the model, held bytes stable, idle data zero.
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] held_a = '0, held_b = '0;
  logic       pa, pb;
  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (hold_a) begin
        check("hold_valid_a", if_a.out_valid, 1);
        check("hold_data_a", if_a.out_data, held_a);
      end
      if (hold_b) begin
        check("hold_valid_b", if_b.out_valid, 1);
        check("hold_data_b", if_b.out_data, held_b);
      end
      if (!if_a.out_valid) check("idle_data_a", if_a.out_data, 0);
      if (!if_b.out_valid) check("idle_data_b", if_b.out_data, 0);
      pa = if_a.out_valid && ready;
      pb = if_b.out_valid && ready;
      if (pa != pb) begin
        check("pop_skew", pb, pa);
      end else if (pa) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_byte: got %02h, required no byte", if_a.out_data);
        end else begin
          check("stream_a", if_a.out_data, exp_q[0]);
          check("stream_b", if_b.out_data, exp_q[0]);
          exp_q.delete(0);
        end
        pop_log.push_back(if_a.out_data);
        pop_cyc.push_back(cyc);
      end
      hold_a = if_a.out_valid && !ready;
      hold_b = if_b.out_valid && !ready;
      held_a = if_a.out_data;
      held_b = if_b.out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1 [4]  = '{8'h42, 8'h52, 8'h52, 8'h45};
  logic [7:0] t3 [9]  = '{8'h52, 8'h42, 8'h52, 8'h42, 8'h42, 8'h52, 8'h42, 8'h52, 8'h45};
  logic [7:0] t4 [4]  = '{8'h52, 8'h42, 8'h52, 8'h52};
  logic [7:0] t6 [4]  = '{8'h42, 8'h52, 8'h52, 8'h45};

  initial begin
    // Reset state
    tick(2);
    check("rst_valid_a", if_a.out_valid, 0);
    check("rst_data_a", if_a.out_data, 0);
    check("rst_done_a", done_a, 0);
    check("rst_fail_b", fail_b, 0);
    check("rst_pass_a", pass_a, 0);
    check("rst_ovf_a", overflow_a, 0);

    // B, R, R with latency check on the first byte
    do_reset(1'b1);
    tray = 32'h6;
    land(5'd1);
    tick(LAT - 1);
    check("latency_early", if_a.out_valid, 0);
    tick(1);
    check("latency_hit", if_a.out_valid, 1);
    tick(5);
    land(5'd2);
    tick(6);
    land(5'd3);
    tick(8);
    finish_run("t1");
    check("t1_count", pop_log.size(), 4);
    foreach (t1[i]) if (i < pop_log.size()) check("t1_byte", pop_log[i], t1[i]);
    check("t1_pass_a_lit", pass_a, 1);
    check("t1_fail_b_lit", fail_b, 1);

    // R, B, B against pattern 1,0,1: mismatch on the third slot only
    do_reset(1'b1);
    tray = 32'h1;
    land(5'd1);
    tick(6);
    land(5'd2);
    tick(10);
    check("t2_fail_before", fail_b, 0);
    land(5'd3);
    tick(10);
    check("t2_fail_after", fail_b, 1);
    finish_run("t2");
    check("t2_pass_b_lit", pass_b, 0);

    // Sink held off: 10 landings, 8 kept, 'E' waits for room
    do_reset(1'b0);
    tray = 32'h2A5;
    land(5'd10);
    tick(25);
    check("t3_valid", if_a.out_valid, 1);
    check("t3_head", if_a.out_data, 8'h52);
    check("t3_ovf_lit", overflow_a, 1);
    no_balls = 1'b1;
    exp_q.push_back(8'h45);
    tick(10);
    check("t3_end_stalled", done_a, 0);
    ready = 1'b1;
    drain_and_check("t3");
    check("t3_count", pop_log.size(), 9);
    foreach (t3[i]) if (i < pop_log.size()) check("t3_byte", pop_log[i], t3[i]);

    // Count wraps 30 -> 2 in one board step
    do_reset(1'b1);
    tray = 32'h4000_0003;
    land(5'd30);
    tick(45);
    pop_log.delete();
    pop_cyc.delete();
    land(5'd2);
    tick(20);
    check("t4_count", pop_log.size(), 4);
    foreach (t4[i]) if (i < pop_log.size()) check("t4_byte", pop_log[i], t4[i]);
    for (int i = 1; i < pop_cyc.size(); i++) check("t4_back_to_back", pop_cyc[i] - pop_cyc[i-1], 1);
    finish_run("t4");

    // One-cycle glitch, then async reset mid-stream, then restart at slot 0
    do_reset(1'b1);
    tray = 32'h1;
    tray_amount = 5'd1;
    tick(1);
    tray_amount = 5'd0;
    tick(12);
    check("t5_glitch_valid", if_a.out_valid, 0);
    check("t5_glitch_count", pop_log.size(), 0);
    ready = 1'b0;
    land(5'd1);
    tick(LAT + 2);
    check("t5_pre_rst_valid", if_a.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid_a", if_a.out_valid, 0);
    check("t5_rst_valid_b", if_b.out_valid, 0);
    check("t5_rst_data_a", if_a.out_data, 0);
    check("t5_rst_done_b", done_b, 0);
    model_clear();
    tray_amount = '0;
    tick(3);
    rst = 1'b0;
    ready = 1'b1;
    tick(LAT);
    land(5'd1);
    tick(LAT + 4);
    check("t5_restart_count", pop_log.size(), 1);
    if (pop_log.size() > 0) check("t5_restart_byte", pop_log[0], 8'h52);
    finish_run("t5");

    // Head held for 5+ cycles while more balls land; order preserved afterwards
    do_reset(1'b0);
    tray = 32'h6;
    land(5'd1);
    tick(LAT + 2);
    land(5'd2);
    tick(3);
    land(5'd3);
    tick(3);
    check("t6_held_head", if_a.out_data, 8'h42);
    check("t6_held_valid", if_a.out_valid, 1);
    tick(8);
    ready = 1'b1;
    tick(8);
    finish_run("t6");
    check("t6_count", pop_log.size(), 4);
    foreach (t6[i]) if (i < pop_log.size()) check("t6_byte", pop_log[i], t6[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
